serial_adder: RTL and testbench

Bit-serial, LSB-first ripple adder and the arithmetic inverse of the team's combinational subtractor cells. It accepts two WIDTH-bit operands and a carry-in with a start pulse. It computes the sum one bit per clock using a single one-bit full-adder cell, then presents the registered sum and carry-out with a one-cycle done pulse. It serves as the area-minimal adder datapath in the arithmetic block library, sitting behind a controller that issues start and waits for done.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_full_adder_cell.sv | 14 +
 rtl/serial_adder.sv | 117 +++++++++++
 tb/tb_serial_adder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional subtract mode is enabled with the SERIAL_ADDER_SUB_EN macro.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bit-counter width. It is at least one bit so that the narrowest
  // adder still has a counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit combinational full adder, the only arithmetic element of serial_adder.
// SERIAL_ADDER_SUB_EN does not affect this cell.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder that processes one bit per clock with a single full adder.
// The SERIAL_ADDER_SUB_EN macro adds the sub port for a - b - cin, with cout as the borrow.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Handshake: start is accepted only on an edge where busy=0. After that
  // edge, busy stays high until done has pulsed for one cycle. The sum and
  // cout outputs are valid from the done cycle until the next done cycle.

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_sh_n;
  logic             carry_q;
  logic             sub_q;
  logic             sub_eff;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last_bit;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  full_adder_cell u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry_q),
    .s   (fa_s),
    .c   (fa_c)
  );

  assign accept   = (state == IDLE) && start;
  assign last_bit = (state == RUN) && (cnt == LAST);

  // The new bit enters at the MSB, so the LSB-first result is already in
  // place once WIDTH bits have been shifted in.
  assign sum_sh_n = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (cnt == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      // Subtract works as a + ~b + ~cin, which equals a - b - cin modulo 2^WIDTH.
      a_sh    <= a;
      b_sh    <= sub_eff ? ~b : b;
      carry_q <= sub_eff ? ~cin : cin;
      sub_q   <= sub_eff;
      cnt     <= '0;
    end else if (state == RUN) begin
      sum_sh  <= sum_sh_n;
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      carry_q <= fa_c;
      cnt     <= cnt + CW'(1);
      if (last_bit) begin
        sum  <= sum_sh_n;
        cout <= fa_c ^ sub_q;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=4). Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
// A cycle-level result model is checked against the DUT on every negedge.
module tb_serial_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub_i;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model state: cycles of busy remaining, and the result being built
  int           m_rem  = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic [W-1:0] m_pend_sum  = '0;
  logic         m_pend_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_i),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the expected result is computed as plain arithmetic on the captured
  // operands. It becomes visible W cycles after acceptance, and busy lasts W+1 cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
    end else if (m_rem == 0) begin
      m_done = 1'b0;
      if (start) begin
        int r;
        if (sub_i) begin
          r = int'(a) - int'(b) - int'(cin);
          m_pend_cout = (r < 0);
          r = r & ((1 << W) - 1);
        end else begin
          r = int'(a) + int'(b) + int'(cin);
          m_pend_cout = r[W];
        end
        m_pend_sum = r[W-1:0];
        m_rem = W + 1;
      end
    end else begin
      m_rem--;
      m_done = (m_rem == 1);
      if (m_rem == 1) begin
        m_sum  = m_pend_sum;
        m_cout = m_pend_cout;
      end
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    check("cyc_busy", 32'(busy), 32'(m_rem != 0));
    check("cyc_done", 32'(done), 32'(m_done));
    check("cyc_sum",  32'(sum),  32'(m_sum));
    check("cyc_cout", 32'(cout), 32'(m_cout));
  end

  // driver: one operation with literal expectations. Call it aligned #1 after posedge in IDLE.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts, input logic [W-1:0] es, input logic ec);
    int bcnt;
    bit got;
    a = ta; b = tb_v; cin = tc; sub_i = ts; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    bcnt = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) got = 1;
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_sum"},   32'(sum),  32'(es));
    check({name, "_cout"},  32'(cout), 32'(ec));
    check({name, "_busy_cycles"}, 32'(bcnt), 32'(W + 1));
    check({name, "_model_sum"},  32'(m_sum),  32'(es));
    check({name, "_model_cout"}, 32'(m_cout), 32'(ec));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[6] = '{
    '{4'd3,  4'd5,  1'b0, 4'd8,  1'b0},
    '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1},
    '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1},
    '{4'd10, 4'd5,  1'b1, 4'd0,  1'b1},
    '{4'd7,  4'd8,  1'b0, 4'd15, 1'b0},
    '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0}
  };

  initial begin
    int pulses;
    int d1, d2;
    logic [W-1:0] got_sum;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum",  32'(sum),  32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op($sformatf("add%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, vecs[i].s, vecs[i].co);

    // operand changes and a second start during RUN are ignored
    a = 4'd6; b = 4'd7; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 a = 4'd1; b = 4'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    pulses = 0; got_sum = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin pulses++; got_sum = sum; end
    end
    check("ignore_pulses", 32'(pulses), 32'd1);
    check("ignore_sum", 32'(got_sum), 32'd13);
    @(posedge clk); #1;

    // asynchronous reset two cycles into RUN
    a = 4'd9; b = 4'd4; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op("after_abort", 4'd9, 4'd4, 1'b1, 1'b0, 4'd14, 1'b0);

    // start held high: back-to-back operations W+2 cycles apart
    a = 4'd2; b = 4'd3; cin = 1'b0; start = 1'b1;
    d1 = -1; d2 = -1;
    for (int i = 0; i < 40 && d2 < 0; i++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) d1 = cyc;
        else d2 = cyc;
      end
    end
    start = 1'b0;
    check("b2b_second_done", 32'(d2 >= 0), 32'd1);
    check("b2b_spacing", 32'(d2 - d1), 32'(W + 2));
    check("b2b_sum", 32'(sum), 32'd5);
    @(posedge clk); #1;

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub0", 4'd2, 4'd5, 1'b0, 1'b1, 4'd13, 1'b1);
    run_op("sub1", 4'd7, 4'd3, 1'b1, 1'b1, 4'd3,  1'b0);
    run_op("sub_off", 4'd7, 4'd3, 1'b1, 1'b0, 4'd11, 1'b0);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
